// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin write arbiter and pop controller for one external FIFO
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   opclear             synchronous operation clear, forwarded as fifo_opclear
//   req0/din0/gnt0      producer 0 write request, data, accept
//   req1/din1/gnt1      producer 1 write request, data, accept
//   pop/pop_ack         consumer read request and accept
//   rd_valid/rd_data    read data strobe (one cycle after pop_ack) and FIFO data
//   full/empty/occ      tracked occupancy and its limits
//   cnt_err             sticky flag: FIFO data_count disagreed with occ
//   fifo_*              connections to the FIFO (wr_en, din, rd_en, opclear, dout, data_count)
//   stall_cnt0/1        per-producer stall counters
//
// Define FIFO_WR_ARB_STATS_EN to build the stall counters; otherwise they read zero.
module fifo_wr_arb #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              opclear,
    input  logic              req0,
    input  logic [DATA_W-1:0] din0,
    output logic              gnt0,
    input  logic              req1,
    input  logic [DATA_W-1:0] din1,
    output logic              gnt1,
    input  logic              pop,
    output logic              pop_ack,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  occ,
    output logic              cnt_err,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_din,
    output logic              fifo_rd_en,
    output logic              fifo_opclear,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic [CNT_W-1:0]  fifo_data_count,
    output logic [15:0]       stall_cnt0,
    output logic [15:0]       stall_cnt1
);
    logic clr;
    logic wr_ok;
    logic last_gnt;
    logic wr;
    always_comb begin
        clr          = reset | opclear;
        full         = occ == CNT_W'(DEPTH);
        empty        = occ == '0;
        wr_ok        = !clr && !full;
        // with both requesting, the producer that did not win last time goes first
        gnt0         = wr_ok && req0 && (!req1 || last_gnt);
        gnt1         = wr_ok && req1 && (!req0 || !last_gnt);
        wr           = gnt0 | gnt1;
        pop_ack      = !clr && pop && !empty;
        fifo_wr_en   = wr;
        fifo_din     = gnt1 ? din1 : din0;
        fifo_rd_en   = pop_ack;
        fifo_opclear = clr;
        rd_data      = fifo_dout;
    end
    always_ff @(posedge clk) begin
        if (clr) begin
            occ      <= '0;
            last_gnt <= 1'b1;
            rd_valid <= 1'b0;
            cnt_err  <= 1'b0;
        end else begin
            occ      <= (wr && !pop_ack) ? occ + 1'b1 : (pop_ack && !wr) ? occ - 1'b1 : occ;
            last_gnt <= gnt0 ? 1'b0 : gnt1 ? 1'b1 : last_gnt;
            rd_valid <= pop_ack;
            cnt_err  <= cnt_err | (fifo_data_count != occ);
        end
    end
`ifdef FIFO_WR_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (clr) begin
            stall_cnt0 <= '0;
            stall_cnt1 <= '0;
        end else begin
            if (req0 && !gnt0 && stall_cnt0 != 16'hFFFF)
                stall_cnt0 <= stall_cnt0 + 1'b1;
            if (req1 && !gnt1 && stall_cnt1 != 16'hFFFF)
                stall_cnt1 <= stall_cnt1 + 1'b1;
        end
    end
`else
    assign stall_cnt0 = 16'h0000;
    assign stall_cnt1 = 16'h0000;
`endif
endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: directed bench for fifo_wr_arb with a behavioural 8x32 FIFO attached
module tb_fifo_wr_arb;
    logic        clk = 0;
    logic        reset, opclear, req0, req1, pop;
    logic [31:0] din0, din1;
    logic        gnt0, gnt1, pop_ack, rd_valid, full, empty, cnt_err;
    logic [31:0] rd_data, fifo_din, fifo_dout;
    logic [3:0]  occ, fifo_data_count, mcnt;
    logic        fifo_wr_en, fifo_rd_en, fifo_opclear;
    logic [15:0] stall_cnt0, stall_cnt1;
    logic        force_en = 0;
    logic [3:0]  force_val = 0;
    logic [31:0] mq[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_wr_arb dut (
        .clk(clk), .reset(reset), .opclear(opclear),
        .req0(req0), .din0(din0), .gnt0(gnt0),
        .req1(req1), .din1(din1), .gnt1(gnt1),
        .pop(pop), .pop_ack(pop_ack), .rd_valid(rd_valid), .rd_data(rd_data),
        .full(full), .empty(empty), .occ(occ), .cnt_err(cnt_err),
        .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .fifo_rd_en(fifo_rd_en),
        .fifo_opclear(fifo_opclear), .fifo_dout(fifo_dout),
        .fifo_data_count(fifo_data_count),
        .stall_cnt0(stall_cnt0), .stall_cnt1(stall_cnt1)
    );

    // behavioural FIFO: registered dout, count updates on the same edge as the write/read
    always @(posedge clk) begin
        if (fifo_opclear) begin
            mq.delete();
            mcnt <= 0;
        end else begin
            if (fifo_rd_en && mq.size() > 0)
                fifo_dout <= mq.pop_front();
            if (fifo_wr_en)
                mq.push_back(fifo_din);
            mcnt <= mcnt + 4'(fifo_wr_en) - 4'(fifo_rd_en && mq.size() > 0);
        end
    end
    assign fifo_data_count = force_en ? force_val : mcnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] exp_stall;
        mcnt = 0;
        fifo_dout = 0;
        reset = 1; opclear = 0; req0 = 1; req1 = 1; pop = 1; din0 = 0; din1 = 0;
        #1;
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_pop_ack", pop_ack, 0);
        chk("rst_opclear", fifo_opclear, 1);
        tick;
        tick;
        chk("rst_occ", occ, 0);
        chk("rst_empty", empty, 1);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_cnt_err", cnt_err, 0);
        reset = 0; pop = 0;
        // fill with both producers contending
        for (int i = 0; i < 8; i++) begin
            din0 = 32'hA000_0000 + 32'((i + 1) / 2);
            din1 = 32'hB000_0000 + 32'(i / 2);
            #1;
            chk("fill_gnt0", gnt0, 32'(i % 2 == 0));
            chk("fill_gnt1", gnt1, 32'(i % 2 == 1));
            chk("fill_din", fifo_din, (i % 2 == 0) ? 32'hA000_0000 + 32'(i / 2) : 32'hB000_0000 + 32'(i / 2));
            tick;
        end
        chk("fill_full", full, 1);
        chk("fill_occ", occ, 8);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("full_no_gnt", {gnt0, gnt1, fifo_wr_en}, 0);
            tick;
        end
`ifdef FIFO_WR_ARB_STATS_EN
        exp_stall = 16'd7;
`else
        exp_stall = 16'd0;
`endif
        chk("stall0", stall_cnt0, exp_stall);
        chk("stall1", stall_cnt1, exp_stall);
        // drain, checking interleaved order
        req0 = 0; req1 = 0; pop = 1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("drain_pop_ack", {pop_ack, fifo_rd_en}, 2'b11);
            tick;
            chk("drain_rd_valid", rd_valid, 1);
            chk("drain_rd_data", rd_data, (i % 2 == 0) ? 32'hA000_0000 + 32'(i / 2) : 32'hB000_0000 + 32'(i / 2));
        end
        chk("drain_empty", empty, 1);
        chk("drain_occ", occ, 0);
        #1;
        chk("empty_pop_ack", pop_ack, 0);
        tick;
        chk("empty_rd_valid", rd_valid, 0);
        // refill with producer 0 alone
        pop = 0; req0 = 1;
        for (int i = 0; i < 8; i++) begin
            din0 = 32'hC000_0000 + 32'(i);
            tick;
        end
        chk("refill_occ", occ, 8);
        pop = 1;
        #1;
        chk("full_pop_ack", pop_ack, 1);
        chk("full_wr_refused", gnt0, 0);
        tick;
        chk("full_pop_occ", occ, 7);
        req0 = 0;
        for (int i = 0; i < 7; i++) tick;
        chk("redrain_occ", occ, 0);
        req1 = 1; din1 = 32'hD000_0000;
        #1;
        chk("empty_gnt1", gnt1, 1);
        chk("empty_pop_refused", pop_ack, 0);
        tick;
        chk("empty_wr_occ", occ, 1);
        chk("empty_wr_rd_valid", rd_valid, 0);
        pop = 0;
        for (int i = 1; i < 5; i++) begin
            din1 = 32'hD000_0000 + 32'(i);
            tick;
        end
        req1 = 0;
        chk("occ5", occ, 5);
        pop = 1; req0 = 1; din0 = 32'hE000_0000;
        #1;
        chk("both_gnt0", gnt0, 1);
        chk("both_pop_ack", pop_ack, 1);
        tick;
        chk("both_occ", occ, 5);
        chk("both_rd_valid", rd_valid, 1);
        chk("both_rd_data", rd_data, 32'hD000_0000);
        // opclear with pop and request pending
        opclear = 1;
        #1;
        chk("clr_gnt0", gnt0, 0);
        chk("clr_pop_ack", pop_ack, 0);
        chk("clr_fifo_opclear", fifo_opclear, 1);
        tick;
        opclear = 0; pop = 0; req0 = 0;
        #1;
        chk("clr_occ", occ, 0);
        chk("clr_rd_valid", rd_valid, 0);
        chk("clr_empty", empty, 1);
        chk("clr_fifo_opclear_off", fifo_opclear, 0);
        // occupancy consistency flag
        req0 = 1;
        tick;
        tick;
        req0 = 0;
        chk("err_occ", occ, 2);
        chk("err_clean", cnt_err, 0);
        force_en = 1; force_val = 3;
        tick;
        force_en = 0;
        chk("err_set", cnt_err, 1);
        tick;
        chk("err_sticky", cnt_err, 1);
        opclear = 1;
        tick;
        opclear = 0;
        chk("err_cleared", cnt_err, 0);
        chk("err_clr_occ", occ, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
